// File: rtl/sdo_capture_if.sv
// Capture-stage bundle: frame control and SO line in; read FIFO, status and flags out.
// The master side is the sequencer/EEPROM side; the slave side is sdo_capture.
interface sdo_capture_if #(
  parameter int OP_CYC = 8
) ();
  logic              csb;
  logic [OP_CYC-1:0] inst;
  logic              sdo;
  logic              rd_en;
  logic              ovf_clr;
  logic [OP_CYC-1:0] rd_data;
  logic              empty;
  logic              full;
  logic              overflow;
  logic              byte_valid;
  logic [OP_CYC-1:0] status_reg;
  logic              wip;

  modport master (
    output csb, inst, sdo, rd_en, ovf_clr,
    input  rd_data, empty, full, overflow, byte_valid, status_reg, wip
  );

  modport slave (
    input  csb, inst, sdo, rd_en, ovf_clr,
    output rd_data, empty, full, overflow, byte_valid, status_reg, wip
  );
endinterface

// File: rtl/sdo_capture.sv
// Deserializes EEPROM SO bytes MSB-first into a show-ahead FIFO and tracks the RDSR status byte.
// Data visible 1 cycle after the completing sample edge; a push into a full FIFO without a pop is dropped and flagged.
module sdo_capture #(
  parameter int CLK_SCK_SCAL = 40,
  parameter int SAMPLE_PT    = 20,
  parameter int OP_CYC       = 8,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic           clk,
  input  logic           reset,
  sdo_capture_if.slave   bus
);
  localparam int CNT_W = $clog2(CLK_SCK_SCAL);
  localparam int IDX_W = (OP_CYC > 1) ? $clog2(OP_CYC) : 1;
  localparam int PTR_W = $clog2(FIFO_DEPTH);

  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(CLK_SCK_SCAL - 1);
  localparam logic [CNT_W-1:0]  CNT_SMP   = CNT_W'(SAMPLE_PT);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(OP_CYC - 1);
  localparam logic [5:0]        HDR_SAT   = 6'd32;
  localparam logic [PTR_W:0]    CNT_FULL  = (PTR_W+1)'(FIFO_DEPTH);
  localparam logic [OP_CYC-1:0] OP_RDSR   = OP_CYC'(8'h05);
  localparam logic [OP_CYC-1:0] OP_READ   = OP_CYC'(8'h03);
  localparam logic [OP_CYC-1:0] OP_FREAD  = OP_CYC'(8'h0B);

  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [5:0]        hdr_cnt_q, hdr_cnt_d;
  logic [IDX_W-1:0]  bit_idx_q, bit_idx_d;
  logic [OP_CYC-1:0] shreg_q, shreg_d;
  logic [OP_CYC-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]    count_q, count_d;
  logic              empty_q, empty_d, full_q, full_d;
  logic              ovf_q, ovf_d, bv_q, bv_d;
  logic [OP_CYC-1:0] status_q, status_d;

  logic              cap_en, wrap, sample, byte_done, pop, do_push;
  logic [5:0]        hdr_len;
  logic [OP_CYC-1:0] new_byte;

  always_comb begin
    cap_en  = 1'b1;
    hdr_len = 6'd8;
    case (bus.inst)
      OP_RDSR:  hdr_len = 6'd8;
      OP_READ:  hdr_len = 6'd24;
      OP_FREAD: hdr_len = 6'd32;
      default:  cap_en  = 1'b0;
    endcase
  end

  always_comb begin
    wrap      = (cnt_q == CNT_LAST);
    sample    = !bus.csb && cap_en && (hdr_cnt_q >= hdr_len) && (cnt_q == CNT_SMP);
    byte_done = sample && (bit_idx_q == IDX_LAST);
    new_byte  = {shreg_q[OP_CYC-2:0], bus.sdo};
    pop       = bus.rd_en && !empty_q;
    do_push   = byte_done && (!full_q || pop);

    cnt_d     = cnt_q;
    hdr_cnt_d = hdr_cnt_q;
    bit_idx_d = bit_idx_q;
    shreg_d   = shreg_q;
    if (bus.csb) begin
      // Frame end: any partial byte is abandoned, FIFO and status survive.
      cnt_d     = '0;
      hdr_cnt_d = '0;
      bit_idx_d = '0;
      shreg_d   = '0;
    end else begin
      cnt_d = wrap ? '0 : cnt_q + 1'b1;
      if (wrap && hdr_cnt_q != HDR_SAT) hdr_cnt_d = hdr_cnt_q + 6'd1;
      if (sample) begin
        shreg_d   = new_byte;
        bit_idx_d = (bit_idx_q == IDX_LAST) ? '0 : bit_idx_q + 1'b1;
      end
    end

    wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    case ({do_push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    full_d  = (count_d == CNT_FULL);
    empty_d = (count_d == '0);

    // A dropping push beats a same-edge clear.
    if (byte_done && full_q && !pop) ovf_d = 1'b1;
    else if (bus.ovf_clr)            ovf_d = 1'b0;
    else                             ovf_d = ovf_q;

    status_d = (byte_done && bus.inst == OP_RDSR) ? new_byte : status_q;
    bv_d     = byte_done;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q     <= '0;
      hdr_cnt_q <= '0;
      bit_idx_q <= '0;
      shreg_q   <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      empty_q   <= 1'b1;
      full_q    <= 1'b0;
      ovf_q     <= 1'b0;
      bv_q      <= 1'b0;
      status_q  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      cnt_q     <= cnt_d;
      hdr_cnt_q <= hdr_cnt_d;
      bit_idx_q <= bit_idx_d;
      shreg_q   <= shreg_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      empty_q   <= empty_d;
      full_q    <= full_d;
      ovf_q     <= ovf_d;
      bv_q      <= bv_d;
      status_q  <= status_d;
      if (do_push) mem_q[wr_ptr_q] <= new_byte;
    end
  end

  assign bus.rd_data    = empty_q ? '0 : mem_q[rd_ptr_q];
  assign bus.empty      = empty_q;
  assign bus.full       = full_q;
  assign bus.overflow   = ovf_q;
  assign bus.byte_valid = bv_q;
  assign bus.status_reg = status_q;
  assign bus.wip        = status_q[0];
endmodule

// File: tb/tb_sdo_capture.sv
// Bench for sdo_capture: EEPROM SO stimulus per frame with a byte/pulse scoreboard and FIFO model.
module tb_sdo_capture;
  localparam int SCAL = 40;
  localparam int SPT  = 20;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  sdo_capture_if #(.OP_CYC(8)) bus ();

  sdo_capture #(
    .CLK_SCK_SCAL(SCAL),
    .SAMPLE_PT(SPT),
    .OP_CYC(8),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  int         n_vec = 0;
  int         n_err = 0;
  logic [7:0] dbuf [0:7];
  logic [7:0] mfifo [$];
  int         exp_bv [$];
  bit         m_ovf;
  logic [7:0] m_status;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] m_head();
    return (mfifo.size() > 0) ? mfifo[0] : 8'h00;
  endfunction

  task automatic check_state();
    chk("rd_data", 32'(bus.rd_data), 32'(m_head()));
    chk("empty", 32'(bus.empty), 32'(mfifo.size() == 0));
    chk("full", 32'(bus.full), 32'(mfifo.size() == DEPTH));
    chk("overflow", 32'(bus.overflow), 32'(m_ovf));
    chk("status_reg", 32'(bus.status_reg), 32'(m_status));
    chk("wip", 32'(bus.wip), 32'(m_status[0]));
  endtask

  // Drives one csb-low frame of nper SCK periods; data bits come from dbuf after hdr periods.
  task automatic frame(input logic [7:0] op, input int hdr, input int nbytes, input int nper,
                       input int pop_at, input bit keep_low);
    int p, d;
    bit comp;
    logic [7:0] b;
    b = 8'h00;
    bus.inst = op;
    bus.csb  = 1'b0;
    for (int n = 1; n <= nper * SCAL; n++) begin
      p = (n - 1) / SCAL;
      d = p - hdr;
      comp = 1'b0;
      if (nbytes > 0 && p >= hdr && d / 8 < nbytes) begin
        b = dbuf[d / 8];
        bus.sdo = b[3'(7 - d % 8)];
        comp = (d % 8 == 7) && ((n - 1) % SCAL == SPT);
      end else begin
        bus.sdo = 1'($urandom);
      end
      bus.rd_en = (n == pop_at);
      if (bus.rd_en) chk("pop_head", 32'(bus.rd_data), 32'(m_head()));
      tick();
      bus.rd_en = 1'b0;
      if (n == pop_at && mfifo.size() > 0) void'(mfifo.pop_front());
      if (comp) begin
        exp_bv.push_back(n);
        if (mfifo.size() < DEPTH) mfifo.push_back(b);
        else m_ovf = 1'b1;
        if (op == 8'h05) m_status = b;
      end
      if (bus.byte_valid) begin
        if (exp_bv.size() == 0) chk("bv_extra", 32'(n), 32'(0));
        else chk("bv_cycle", 32'(n), 32'(exp_bv.pop_front()));
      end
    end
    if (!keep_low) begin
      bus.csb = 1'b1;
      tick();
      tick();
    end
    chk("bv_missing", 32'(exp_bv.size()), 32'(0));
    exp_bv.delete();
  endtask

  task automatic drain();
    for (int i = 0; i < 2 * DEPTH && mfifo.size() > 0; i++) begin
      chk("drain_head", 32'(bus.rd_data), 32'(mfifo[0]));
      bus.rd_en = 1'b1;
      tick();
      bus.rd_en = 1'b0;
      void'(mfifo.pop_front());
    end
    chk("drain_empty", 32'(bus.empty), 32'(1));
    chk("drain_rd_data", 32'(bus.rd_data), 32'(0));
  endtask

  initial begin
    reset       = 1'b1;
    bus.csb     = 1'b1;
    bus.inst    = 8'h00;
    bus.sdo     = 1'b0;
    bus.rd_en   = 1'b0;
    bus.ovf_clr = 1'b0;
    m_ovf       = 1'b0;
    m_status    = 8'h00;
    #1;
    check_state();
    chk("reset_bv", 32'(bus.byte_valid), 32'(0));
    tick();
    tick();
    reset = 1'b0;
    tick();

    // RDSR returning 0x83.
    dbuf[0] = 8'h83;
    frame(8'h05, 8, 1, 16, -1, 1'b0);
    check_state();
    drain();

    // READ of two bytes.
    dbuf[0] = 8'hA5;
    dbuf[1] = 8'h3C;
    frame(8'h03, 24, 2, 40, -1, 1'b0);
    check_state();
    drain();

    // Non-capturing opcode with random SO.
    frame(8'h02, 0, 0, 40, -1, 1'b0);
    check_state();

    // Aborted READ mid first byte, then a clean READ.
    dbuf[0] = 8'hFF;
    frame(8'h03, 24, 1, 28, -1, 1'b0);
    check_state();
    dbuf[0] = 8'h5A;
    frame(8'h03, 24, 1, 32, -1, 1'b0);
    check_state();
    drain();

    // Overflow, clear, then push and pop on the same edge while full.
    for (int i = 0; i < 6; i++) dbuf[i] = 8'(i + 1);
    frame(8'h03, 24, 6, 72, -1, 1'b0);
    check_state();
    bus.ovf_clr = 1'b1;
    tick();
    bus.ovf_clr = 1'b0;
    m_ovf = 1'b0;
    chk("ovf_cleared", 32'(bus.overflow), 32'(0));
    dbuf[0] = 8'h77;
    frame(8'h03, 24, 1, 32, (24 + 7) * SCAL + SPT + 1, 1'b0);
    check_state();
    drain();

    // Asynchronous reset in the middle of the second byte of a READ.
    dbuf[0] = 8'hE1;
    dbuf[1] = 8'h55;
    frame(8'h03, 24, 2, 35, -1, 1'b1);
    check_state();
    #2;
    reset = 1'b1;
    #1;
    chk("arst_rd_data", 32'(bus.rd_data), 32'(0));
    chk("arst_empty", 32'(bus.empty), 32'(1));
    chk("arst_full", 32'(bus.full), 32'(0));
    chk("arst_overflow", 32'(bus.overflow), 32'(0));
    chk("arst_bv", 32'(bus.byte_valid), 32'(0));
    chk("arst_status", 32'(bus.status_reg), 32'(0));
    chk("arst_wip", 32'(bus.wip), 32'(0));
    mfifo.delete();
    m_ovf    = 1'b0;
    m_status = 8'h00;
    tick();
    bus.csb = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    dbuf[0] = 8'h81;
    frame(8'h05, 8, 1, 16, -1, 1'b0);
    check_state();
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
